debug_unit_mips: RTL and testbench

//  Run/step/dump controller for the top_mips pipeline. Decodes command bytes from a UART RX,

---
 rtl/debug_unit_mips_if.sv | 26 ++
 rtl/debug_unit_mips.sv | 126 ++++++++++++
 tb/tb_debug_unit_mips.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/debug_unit_mips_if.sv
// Signals between the debug unit, the UART byte streams and the MIPS pipeline.
// The master side is the debug unit; the slave side is the board or testbench around it.
interface debug_unit_mips_if #(parameter int LEN = 32);
  logic           rx_valid;
  logic [7:0]     rx_data;
  logic           tx_ready;
  logic           tx_valid;
  logic [7:0]     tx_data;
  logic           halt_flag;
  logic [LEN-1:0] in_pc;
  logic [LEN-1:0] in_reg1;
  logic [LEN-1:0] in_mem;
  logic           mips_clk_en;
  logic           mips_reset;
  logic           debug_flag;
  logic [LEN-1:0] addr_debug;

  modport master (
    input  rx_valid, rx_data, tx_ready, halt_flag, in_pc, in_reg1, in_mem,
    output tx_valid, tx_data, mips_clk_en, mips_reset, debug_flag, addr_debug
  );
  modport slave (
    output rx_valid, rx_data, tx_ready, halt_flag, in_pc, in_reg1, in_mem,
    input  tx_valid, tx_data, mips_clk_en, mips_reset, debug_flag, addr_debug
  );
endinterface

// File: rtl/debug_unit_mips.sv
// Run/step/dump controller for the MIPS pipeline: decodes UART command bytes, gates the
// pipeline clock, and streams PC, register file and data memory out LSB-first over TX.
module debug_unit_mips #(
  parameter int LEN         = 32,
  parameter int NB          = 5,
  parameter int N_REGS      = 32,
  parameter int N_MEM_WORDS = 16,
  parameter int READ_LAT    = 2
)(
  input  logic               clk,
  input  logic               reset,
  debug_unit_mips_if.master  bus
);
  localparam int N_WORDS = 1 + N_REGS + N_MEM_WORDS;
  localparam int WW      = $clog2(N_WORDS + 1);
  localparam int LW      = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_STEP, S_LOAD, S_SEND} state_t;

  state_t         r_state, w_next;
  logic           r_halted, r_tx_valid, r_mips_reset;
  logic [7:0]     r_tx_data;
  logic [LEN-1:0] r_addr, r_shift;
  logic [WW-1:0]  r_word;
  logic [1:0]     r_byte;
  logic [LW-1:0]  r_lat;
  logic           w_cmd_run, w_cmd_step, w_cmd_rst, w_lat_done, w_xfer, w_last_byte, w_last_word;

  assign w_cmd_run   = (r_state == S_IDLE) && bus.rx_valid && (bus.rx_data == 8'h63) && !r_halted;
  assign w_cmd_step  = (r_state == S_IDLE) && bus.rx_valid && (bus.rx_data == 8'h73) && !r_halted;
  assign w_cmd_rst   = (r_state == S_IDLE) && bus.rx_valid && (bus.rx_data == 8'h72);
  // The PC word is already on in_pc; every other word waits for the read ports to settle.
  assign w_lat_done  = (r_word == '0) || (r_lat == LW'(READ_LAT - 1));
  assign w_xfer      = r_tx_valid && bus.tx_ready;
  assign w_last_byte = (r_byte == 2'd3);
  assign w_last_word = (r_word == WW'(N_WORDS - 1));

  assign bus.tx_valid   = r_tx_valid;
  assign bus.tx_data    = r_tx_data;
  assign bus.mips_reset = r_mips_reset;
  assign bus.addr_debug = r_addr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_cmd_run) w_next = S_RUN;
              else if (w_cmd_step) w_next = S_STEP;
      S_RUN:  if (bus.halt_flag) w_next = S_LOAD;
      S_STEP: w_next = S_LOAD;
      S_LOAD: if (w_lat_done) w_next = S_SEND;
      S_SEND: if (w_xfer && w_last_byte) w_next = w_last_word ? S_IDLE : S_LOAD;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.mips_clk_en = 1'b0;
    bus.debug_flag  = 1'b0;
    case (r_state)
      S_RUN, S_STEP:  bus.mips_clk_en = 1'b1;
      S_LOAD, S_SEND: bus.debug_flag  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_halted     <= 1'b0;
      r_tx_valid   <= 1'b0;
      r_tx_data    <= '0;
      r_mips_reset <= 1'b1;
      r_addr       <= '0;
      r_shift      <= '0;
      r_word       <= '0;
      r_byte       <= '0;
      r_lat        <= '0;
    end else begin
      r_mips_reset <= w_cmd_rst;
      if (w_cmd_rst) r_halted <= 1'b0;
      else if ((r_state == S_RUN || r_state == S_STEP) && bus.halt_flag) r_halted <= 1'b1;
      case (r_state)
        S_RUN, S_STEP: begin
          r_word <= '0;
          r_addr <= '0;
          r_byte <= '0;
          r_lat  <= '0;
        end
        S_LOAD: begin
          if (w_lat_done)
            r_shift <= (r_word == '0)           ? bus.in_pc :
                       (r_word <= WW'(N_REGS))  ? bus.in_reg1 : bus.in_mem;
          else
            r_lat <= r_lat + 1'b1;
        end
        S_SEND: begin
          // Valid drops for a cycle after each transfer, then the next byte is presented.
          if (!r_tx_valid) begin
            r_tx_valid <= 1'b1;
            r_tx_data  <= r_shift[7:0];
          end else if (bus.tx_ready) begin
            r_tx_valid <= 1'b0;
            r_shift    <= r_shift >> 8;
            r_byte     <= r_byte + 1'b1;
            if (w_last_byte) begin
              r_lat <= '0;
              if (w_last_word) begin
                r_word <= '0;
                r_addr <= '0;
              end else begin
                r_word <= r_word + 1'b1;
                r_addr <= (r_word < WW'(N_REGS)) ? LEN'(r_word[NB-1:0])
                                                 : LEN'(r_word - WW'(N_REGS));
              end
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_debug_unit_mips.sv
// Directed bench for debug_unit_mips: a pipeline/memory stand-in drives the read ports and
// a byte-queue model of the dump stream is compared against every TX transfer.
module tb_debug_unit_mips;
  localparam int HALT_AT = 10;
  localparam logic [31:0] PC_BASE = 32'h0040_0000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  debug_unit_mips_if #(.LEN(32)) bus ();

  debug_unit_mips #(.LEN(32), .NB(5), .N_REGS(32), .N_MEM_WORDS(16), .READ_LAT(2)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  // Pipeline stand-in: instruction count advances on each enabled clock.
  int          pcnt = 0;
  bit          force_halt = 1'b0;
  logic [31:0] addr_d = '0;
  logic [31:0] regs [32];
  logic [31:0] mems [16];

  always @(posedge clk) begin
    if (bus.mips_reset)       pcnt <= 0;
    else if (bus.mips_clk_en) pcnt <= pcnt + 1;
    addr_d <= bus.addr_debug;
  end

  assign bus.halt_flag = (pcnt >= HALT_AT - 1) || force_halt;
  assign bus.in_pc     = PC_BASE + 32'(pcnt) * 32'd4;
  assign bus.in_reg1   = regs[addr_d[4:0]];
  assign bus.in_mem    = mems[addr_d[3:0]];

  int         nchk = 0, nerr = 0, nbytes = 0, rst_hi = 0, m_pcnt = 0;
  bit         m_halted = 1'b0;
  logic [7:0] exp_q [$];

  function automatic void chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (!ok) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic bit halt_at(input int q);
    return (q >= HALT_AT - 1) || force_halt;
  endfunction

  function automatic void push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) exp_q.push_back(w[8*i +: 8]);
  endfunction

  function automatic void push_dump(input int p);
    push_word(PC_BASE + 32'(p) * 32'd4);
    for (int i = 0; i < 32; i++) push_word(regs[i]);
    for (int j = 0; j < 16; j++) push_word(mems[j]);
  endfunction

  // Command semantics: what the pipeline count, halted flag and dump stream must become.
  function automatic void model_cmd(input logic [7:0] b);
    int q;
    if (b == 8'h72) begin
      m_halted = 1'b0;
      m_pcnt   = 0;
    end else if ((b == 8'h63 || b == 8'h73) && !m_halted) begin
      q = m_pcnt;
      if (b == 8'h63) begin
        while (!halt_at(q)) q++;
        m_halted = 1'b1;
      end else begin
        m_halted = halt_at(q);
      end
      m_pcnt = q + 1;
      push_dump(m_pcnt);
    end
  endfunction

  task automatic check_reset(input string tag);
    chk(bus.tx_valid == 1'b0,    {tag, "_tx_valid"},   32'(bus.tx_valid), 32'd0);
    chk(bus.tx_data == 8'h00,    {tag, "_tx_data"},    32'(bus.tx_data), 32'd0);
    chk(bus.mips_clk_en == 1'b0, {tag, "_clk_en"},     32'(bus.mips_clk_en), 32'd0);
    chk(bus.mips_reset == 1'b1,  {tag, "_mips_reset"}, 32'(bus.mips_reset), 32'd1);
    chk(bus.debug_flag == 1'b0,  {tag, "_debug_flag"}, 32'(bus.debug_flag), 32'd0);
    chk(bus.addr_debug == '0,    {tag, "_addr"},       bus.addr_debug, 32'd0);
  endtask

  // Compare process: every transfer against the model queue, plus handshake/flag rules.
  task automatic monitor();
    bit pv = 0, pxfer = 0, pdbg = 0, xfer;
    logic [7:0] pd = '0, e;
    forever begin
      @(negedge clk);
      if (reset) begin
        pv = 0; pxfer = 0; pdbg = 0;
        continue;
      end
      if (bus.mips_reset) rst_hi++;
      if (bus.debug_flag) chk(!bus.mips_clk_en, "clk_en_in_dump", 32'(bus.mips_clk_en), 32'd0);
      if (bus.tx_valid)   chk(bus.debug_flag, "tx_without_debug_flag", 32'(bus.debug_flag), 32'd1);
      if (pv && !pxfer)
        chk(bus.tx_valid && bus.tx_data == pd, "tx_hold", {23'd0, bus.tx_valid, bus.tx_data}, {23'd0, 1'b1, pd});
      xfer = bus.tx_valid && bus.tx_ready;
      if (xfer) begin
        chk(exp_q.size() != 0, "tx_unexpected_byte", 32'(bus.tx_data), 32'd0);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk(bus.tx_data == e, "tx_byte", 32'(bus.tx_data), 32'(e));
        end
        nbytes++;
      end
      if (pdbg && !bus.debug_flag) chk(exp_q.size() == 0, "dump_ended_early", 32'(exp_q.size()), 32'd0);
      pv = bus.tx_valid; pd = bus.tx_data; pxfer = xfer; pdbg = bus.debug_flag;
    end
  endtask

  // Issue one command and run until idle; optional stall, reset or stray rx at a dump byte index.
  task automatic do_cmd(input logic [7:0] b, input int stall_b, input int rst_b, input int inj_b, output int nb);
    int base;
    bit done, stld, rstd, injd;
    base = nbytes; done = 0; stld = 0; rstd = 0; injd = 0;
    model_cmd(b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
      @(posedge clk); #1;
      bus.rx_valid = 1'b0;
      if (inj_b >= 0 && !injd && nbytes - base == inj_b) begin
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h73;
        injd = 1;
      end
      if (stall_b >= 0 && !stld && bus.tx_valid && nbytes - base == stall_b) begin
        chk(bus.tx_data == 8'hEF, "stall_first_byte", 32'(bus.tx_data), 32'hEF);
        bus.tx_ready = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        chk(bus.tx_valid && bus.tx_data == 8'hEF, "stall_end_hold", {23'd0, bus.tx_valid, bus.tx_data}, 32'h1EF);
        bus.tx_ready = 1'b1;
        stld = 1;
      end
      if (rst_b >= 0 && !rstd && bus.tx_valid && nbytes - base == rst_b) begin
        reset = 1'b1;
        #1;
        check_reset("abort");
        exp_q.delete();
        m_halted = 1'b0;
        m_pcnt   = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        rstd = 1;
      end
      done = cyc > 0 && !bus.debug_flag && !bus.mips_clk_en && exp_q.size() == 0 && !bus.rx_valid;
    end
    chk(done, "cmd_timeout", 32'(exp_q.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk(pcnt == m_pcnt, "clk_en_cycles", 32'(pcnt), 32'(m_pcnt));
    nb = nbytes - base;
  endtask

  initial begin
    int nb, s0;
    for (int i = 0; i < 32; i++) regs[i] = 32'h1100_0000 + 32'(i) * 32'h0101_0101;
    regs[0] = 32'h0;
    regs[4] = 32'hDEAD_BEEF;
    for (int j = 0; j < 16; j++) mems[j] = 32'hA500_0000 + 32'(j) * 32'h0000_1111;
    reset = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.tx_ready = 1'b1;
    fork monitor(); join_none

    repeat (3) @(posedge clk);
    #1;
    check_reset("por");
    reset = 1'b0;
    #1 chk(bus.mips_reset == 1'b1, "mips_reset_until_clk", 32'(bus.mips_reset), 32'd1);
    @(posedge clk); #1;
    chk(bus.mips_reset == 1'b0, "mips_reset_release", 32'(bus.mips_reset), 32'd0);

    do_cmd(8'h41, -1, -1, -1, nb);
    chk(nb == 0, "unknown_byte_ignored", 32'(nb), 32'd0);

    // Run to halt: ten enabled cycles, then the full dump.
    do_cmd(8'h63, -1, -1, -1, nb);
    chk(nb == 196, "run_bytes", 32'(nb), 32'd196);
    chk(pcnt == 10, "run_clk_en_cycles", 32'(pcnt), 32'd10);

    // Halted: run/step ignored; 'r' pulses mips_reset once and re-arms.
    do_cmd(8'h63, -1, -1, -1, nb);
    chk(nb == 0, "halted_run_ignored", 32'(nb), 32'd0);
    do_cmd(8'h73, -1, -1, -1, nb);
    chk(nb == 0, "halted_step_ignored", 32'(nb), 32'd0);
    s0 = rst_hi;
    do_cmd(8'h72, -1, -1, -1, nb);
    chk(rst_hi - s0 == 1, "mips_reset_pulse_width", 32'(rst_hi - s0), 32'd1);
    do_cmd(8'h63, -1, -1, -1, nb);
    chk(nb == 196, "rerun_bytes", 32'(nb), 32'd196);
    chk(pcnt == 10, "rerun_clk_en_cycles", 32'(pcnt), 32'd10);

    // Single steps, one with a stray command mid-dump and one with a TX stall.
    do_cmd(8'h72, -1, -1, -1, nb);
    do_cmd(8'h73, -1, -1, -1, nb);
    chk(nb == 196, "step_bytes", 32'(nb), 32'd196);
    chk(pcnt == 1, "step_one_cycle", 32'(pcnt), 32'd1);
    do_cmd(8'h73, -1, -1, 40, nb);
    chk(nb == 196, "step_during_dump_bytes", 32'(nb), 32'd196);
    chk(pcnt == 2, "step_during_dump_no_extra", 32'(pcnt), 32'd2);
    do_cmd(8'h73, 20, -1, -1, nb);
    chk(nb == 196, "stall_dump_bytes", 32'(nb), 32'd196);

    // Reset while byte 2 of word 20 is on the wire, then a fresh step dump.
    do_cmd(8'h73, -1, 82, -1, nb);
    chk(nb == 82, "aborted_dump_bytes", 32'(nb), 32'd82);
    do_cmd(8'h73, -1, -1, -1, nb);
    chk(nb == 196, "post_abort_dump_bytes", 32'(nb), 32'd196);
    chk(pcnt == 1, "post_abort_pcnt", 32'(pcnt), 32'd1);

    // Step up to the halt: the halting step sets halted.
    for (int k = 0; k < 8; k++) do_cmd(8'h73, -1, -1, -1, nb);
    chk(pcnt == 9, "steps_to_nine", 32'(pcnt), 32'd9);
    do_cmd(8'h73, -1, -1, -1, nb);
    chk(nb == 196, "halting_step_bytes", 32'(nb), 32'd196);
    do_cmd(8'h73, -1, -1, -1, nb);
    chk(nb == 0, "after_halting_step_ignored", 32'(nb), 32'd0);

    // Halt already asserted when RUN starts: exactly one enabled cycle.
    do_cmd(8'h72, -1, -1, -1, nb);
    force_halt = 1'b1;
    do_cmd(8'h63, -1, -1, -1, nb);
    chk(nb == 196, "halt_on_entry_bytes", 32'(nb), 32'd196);
    chk(pcnt == 1, "halt_on_entry_one_cycle", 32'(pcnt), 32'd1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
